microwave_cook_sequencer: RTL and testbench



---
 rtl/microwave_cook_sequencer.sv | 132 +++++++++++++
 tb/tb_microwave_cook_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_sequencer.sv
// microwave_cook_sequencer: keypad time entry, BCD MM:SS countdown, start/pause/clear
// sequencing and power-level duty cycling of the magnetron.
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   startn, stopn              active-low buttons, falling edge acts
//   clearn                     active-low level clear
//   door_closed                1 = door closed
//   key_valid, key_digit       keypad strobe and digit (>9 ignored)
//   power_sel                  power level 1..10 (0 or >10 means 10)
//   mins_tens..secs_ones       BCD display digits
//   cooking, magnetron_on      cook state flag, magnetron enable
//   timer_done                 one-cycle pulse on reaching 00:00
//   beep                       end-of-cook beeper
module microwave_cook_sequencer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int POWER_WINDOW  = 10,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic [3:0] power_sel,
    output logic [3:0] mins_tens,
    output logic [3:0] mins_ones,
    output logic [3:0] secs_tens,
    output logic [3:0] secs_ones,
    output logic       cooking,
    output logic       magnetron_on,
    output logic       timer_done,
    output logic       beep
);
    localparam int TW = $clog2(TICKS_PER_SEC);
    localparam int WW = $clog2(POWER_WINDOW + 1);
    localparam int BW = $clog2(BEEP_SECS + 1);
    typedef enum logic [2:0] {IDLE, SET, COOK, PAUSE, DONE} state_t;
    state_t state, state_next;
    logic [TW-1:0] tick_cnt;
    logic [WW-1:0] win_cnt;
    logic [BW-1:0] beep_cnt;
    logic [3:0] power_q, power_in;
    logic [3:0] dmt, dmo, dst, dso;
    logic prev_startn, prev_stopn;
    logic start_edge, stop_edge, key_ok, wrap, zero_time, last_sec, secs_zero;
    always_comb begin
        start_edge = prev_startn & ~startn;
        stop_edge  = prev_stopn & ~stopn;
        key_ok     = key_valid && key_digit <= 4'd9;
        wrap       = tick_cnt == TW'(TICKS_PER_SEC - 1);
        zero_time  = {mins_tens, mins_ones, secs_tens, secs_ones} == 16'h0;
        last_sec   = {mins_tens, mins_ones, secs_tens} == 12'h0 && secs_ones == 4'd1;
        secs_zero  = secs_tens == 4'd0 && secs_ones == 4'd0;
        power_in   = (power_sel == 4'd0 || power_sel > 4'd10) ? 4'd10 : power_sel;
        // One-second BCD decrement with borrow into minutes; 00 seconds becomes 59
        dso = secs_ones != 4'd0 ? secs_ones - 4'd1 : 4'd9;
        dst = secs_ones != 4'd0 ? secs_tens : (secs_tens != 4'd0 ? secs_tens - 4'd1 : 4'd5);
        dmo = !secs_zero ? mins_ones : (mins_ones != 4'd0 ? mins_ones - 4'd1 : 4'd9);
        dmt = (!secs_zero || mins_ones != 4'd0) ? mins_tens : mins_tens - 4'd1;
    end
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end
    always_comb begin
        state_next = state;
        if (!clearn) state_next = IDLE;
        else begin
            case (state)
                IDLE:    state_next = (start_edge && door_closed) ? COOK : (key_ok ? SET : IDLE);
                SET:     state_next = stop_edge ? IDLE
                                    : (start_edge && door_closed && !zero_time) ? COOK : SET;
                COOK:    state_next = (!door_closed || stop_edge) ? PAUSE
                                    : (wrap && last_sec) ? DONE : COOK;
                PAUSE:   state_next = stop_edge ? IDLE : (start_edge && door_closed) ? COOK : PAUSE;
                DONE:    state_next = (start_edge || stop_edge || key_valid ||
                                       (wrap && beep_cnt == BW'(BEEP_SECS - 1))) ? IDLE : DONE;
                default: state_next = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            {mins_tens, mins_ones, secs_tens, secs_ones} <= 16'h0;
            tick_cnt    <= '0;
            win_cnt     <= '0;
            beep_cnt    <= '0;
            power_q     <= 4'd10;
            prev_startn <= 1'b1;
            prev_stopn  <= 1'b1;
        end else begin
            prev_startn <= startn;
            prev_stopn  <= stopn;
            if (state_next == IDLE) begin
                {mins_tens, mins_ones, secs_tens, secs_ones} <= 16'h0;
                tick_cnt <= '0;
                win_cnt  <= '0;
                beep_cnt <= '0;
            end else if (state_next == COOK && state != COOK) begin
                power_q <= power_in;
                // Resuming from PAUSE keeps the partial second and window position
                if (state != PAUSE) begin
                    tick_cnt <= '0;
                    win_cnt  <= '0;
                end
                if (state == IDLE) {mins_tens, mins_ones, secs_tens, secs_ones} <= 16'h0030;
            end else if (state == COOK && state_next != PAUSE) begin
                tick_cnt <= wrap ? '0 : tick_cnt + TW'(1);
                if (wrap) begin
                    win_cnt <= win_cnt == WW'(POWER_WINDOW - 1) ? '0 : win_cnt + WW'(1);
                    if (!zero_time) {mins_tens, mins_ones, secs_tens, secs_ones} <= {dmt, dmo, dst, dso};
                end
            end else if (state == DONE) begin
                tick_cnt <= wrap ? '0 : tick_cnt + TW'(1);
                if (wrap) beep_cnt <= beep_cnt + BW'(1);
            end else if (key_ok && state_next == SET) begin
                {mins_tens, mins_ones, secs_tens, secs_ones} <= {mins_ones, secs_tens, secs_ones, key_digit};
            end
        end
    end
    always_comb begin
        cooking      = state == COOK;
        beep         = state == DONE;
        timer_done   = state == COOK && state_next == DONE;
        // window_cnt < power*WINDOW/10 rewritten without a divider
        magnetron_on = state == COOK &&
                       (32'(win_cnt) + 32'd1) * 32'd10 <= 32'(power_q) * 32'(POWER_WINDOW);
    end
endmodule

// File: tb/tb_microwave_cook_sequencer.sv
// tb_microwave_cook_sequencer: directed self-checking bench for the cook sequencer.
module tb_microwave_cook_sequencer;
    logic clk = 1'b0;
    logic rstn = 1'b0, startn = 1'b1, stopn = 1'b1, clearn = 1'b1, door_closed = 1'b1;
    logic key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0, power_sel = 4'd10;
    logic [3:0] mins_tens, mins_ones, secs_tens, secs_ones;
    logic cooking, magnetron_on, timer_done, beep;
    logic [15:0] disp;
    int checks = 0, errors = 0;
    microwave_cook_sequencer #(
        .TICKS_PER_SEC(4),
        .POWER_WINDOW(10),
        .BEEP_SECS(3)
    ) dut (
        .clk(clk), .rstn(rstn), .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed), .key_valid(key_valid), .key_digit(key_digit),
        .power_sel(power_sel), .mins_tens(mins_tens), .mins_ones(mins_ones),
        .secs_tens(secs_tens), .secs_ones(secs_ones), .cooking(cooking),
        .magnetron_on(magnetron_on), .timer_done(timer_done), .beep(beep)
    );
    assign disp = {mins_tens, mins_ones, secs_tens, secs_ones};
    always #5 clk = ~clk;
    typedef struct {
        logic startn, stopn, door, kv;
        logic [3:0] kd;
        logic [15:0] disp;
        logic cook, mag;
    } vec_t;
    vec_t vt[18];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask
    task automatic press_key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
    initial begin
        int n;
        int seen;
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  16'h0000, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  16'h0009, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  16'h0099, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  16'h0999, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd9,  16'h9999, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  16'h9997, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd1,  16'h0001, 1'b0, 1'b0};
        vt[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd3,  16'h0013, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 16'h0013, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  16'h0130, 1'b0, 1'b0};
        vt[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0130, 1'b0, 1'b0};
        vt[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0130, 1'b0, 1'b0};
        vt[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  16'h0130, 1'b1, 1'b1};
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_disp", disp, 16'h0);
        chk("rst_cooking", cooking, 0);
        chk("rst_mag", magnetron_on, 0);
        chk("rst_beep", beep, 0);
        chk("rst_done", timer_done, 0);
        rstn = 1'b1;
        @(negedge clk);
        // Quick start: 00:30, countdown, done pulse, beep
        startn = 1'b0;
        @(negedge clk);
        chk("qs_disp", disp, 16'h0030);
        chk("qs_cooking", cooking, 1);
        chk("qs_mag", magnetron_on, 1);
        @(negedge clk);
        startn = 1'b1;
        repeat (2) @(negedge clk);
        chk("qs_hold_0030", disp, 16'h0030);
        @(negedge clk);
        chk("qs_first_dec", disp, 16'h0029);
        n = 0;
        while (!timer_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("qs_done_latency", n, 115);
        chk("qs_done_disp", disp, 16'h0001);
        @(negedge clk);
        chk("qs_done_pulse_end", timer_done, 0);
        chk("qs_done_disp0", disp, 16'h0000);
        chk("qs_done_mag", magnetron_on, 0);
        n = 0;
        while (beep && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("qs_beep_len", n, 12);
        chk("qs_idle_cooking", cooking, 0);
        // Reset mid-cook
        startn = 1'b0;
        @(negedge clk);
        startn = 1'b1;
        repeat (9) @(negedge clk);
        chk("rc_cooking", cooking, 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rc_disp", disp, 16'h0);
        chk("rc_cooking0", cooking, 0);
        chk("rc_mag", magnetron_on, 0);
        chk("rc_beep", beep, 0);
        rstn = 1'b1;
        @(negedge clk);
        // Table: key entry, zero-time start, 5th key, stop, door-open start
        for (int i = 0; i < 18; i++) begin
            startn = vt[i].startn;
            stopn = vt[i].stopn;
            door_closed = vt[i].door;
            key_valid = vt[i].kv;
            key_digit = vt[i].kd;
            @(negedge clk);
            chk($sformatf("vec%0d_disp", i), disp, vt[i].disp);
            chk($sformatf("vec%0d_cook", i), cooking, vt[i].cook);
            chk($sformatf("vec%0d_mag", i), magnetron_on, vt[i].mag);
        end
        key_valid = 1'b0;
        startn = 1'b1;
        // 01:30 countdown with minute borrow
        repeat (3) @(negedge clk);
        chk("mb_hold", disp, 16'h0130);
        @(negedge clk);
        chk("mb_first", disp, 16'h0129);
        repeat (119) @(negedge clk);
        chk("mb_0100", disp, 16'h0100);
        @(negedge clk);
        chk("mb_0059", disp, 16'h0059);
        startn = 1'b0;
        stopn = 1'b0;
        @(negedge clk);
        chk("ss_cooking", cooking, 0);
        chk("ss_mag", magnetron_on, 0);
        chk("ss_disp", disp, 16'h0059);
        startn = 1'b1;
        stopn = 1'b1;
        @(negedge clk);
        chk("ss_pause_hold", cooking, 0);
        stopn = 1'b0;
        @(negedge clk);
        chk("ss_stop_clear", disp, 16'h0000);
        stopn = 1'b1;
        @(negedge clk);
        // Door pause and resume, total 10 s of cooking
        press_key(4'd1);
        press_key(4'd0);
        startn = 1'b0;
        @(negedge clk);
        chk("dp_disp", disp, 16'h0010);
        chk("dp_cooking", cooking, 1);
        startn = 1'b1;
        repeat (6) @(negedge clk);
        chk("dp_0009", disp, 16'h0009);
        door_closed = 1'b0;
        @(negedge clk);
        chk("dp_pause_cook", cooking, 0);
        chk("dp_pause_mag", magnetron_on, 0);
        chk("dp_pause_disp", disp, 16'h0009);
        repeat (5) @(negedge clk);
        chk("dp_frozen", disp, 16'h0009);
        door_closed = 1'b1;
        startn = 1'b0;
        @(negedge clk);
        chk("dp_resume", cooking, 1);
        startn = 1'b1;
        n = 0;
        while (!timer_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dp_remaining", n, 33);
        @(negedge clk);
        chk("dp_beep", beep, 1);
        key_valid = 1'b1;
        key_digit = 4'd5;
        @(negedge clk);
        key_valid = 1'b0;
        chk("dp_key_exit_beep", beep, 0);
        chk("dp_key_exit_disp", disp, 16'h0000);
        // Power 3 duty cycle over 20 s
        press_key(4'd2);
        press_key(4'd0);
        power_sel = 4'd3;
        startn = 1'b0;
        @(negedge clk);
        startn = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (i % 4 == 0) chk($sformatf("p3_mag_s%0d", i / 4), magnetron_on, ((i / 4) % 10) < 3);
            if (i < 79) @(negedge clk);
        end
        chk("p3_done", timer_done, 1);
        @(negedge clk);
        stopn = 1'b0;
        @(negedge clk);
        chk("p3_stop_exit", beep, 0);
        stopn = 1'b1;
        @(negedge clk);
        // Power 0 treated as continuous, then clear mid-cook
        power_sel = 4'd0;
        startn = 1'b0;
        @(negedge clk);
        startn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) chk($sformatf("p0_mag_s%0d", i / 4), magnetron_on, 1);
            @(negedge clk);
        end
        n = 0;
        while (disp != 16'h0007 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cl_reach_0007", disp, 16'h0007);
        clearn = 1'b0;
        @(negedge clk);
        chk("cl_disp", disp, 16'h0);
        chk("cl_cooking", cooking, 0);
        chk("cl_mag", magnetron_on, 0);
        clearn = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (timer_done || cooking) seen++;
            @(negedge clk);
        end
        chk("cl_no_done", seen, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
